cam_capture: RTL
================

// Module: cam_capture
// PURPOSE
//  Sink end of the camera pixel stream (pclk/value/x/y/is_val, one pixel per valid strobe,
//  raster order). Captures whole frames into an external double-banked frame buffer via a
//  registered write port. Publishes completed banks to a downstream consumer and drops
//  frames when no bank is free or the stream is out of sequence.
// PARAMETERS
//  ROW_SZ   320  pixels per row (x range 0..ROW_SZ-1)
//  COL_SZ   240  rows per frame (y range 0..COL_SZ-1)
//  AW       17   write address width; must satisfy 2**AW >= ROW_SZ*COL_SZ
// PORTS
//  clk          in   1   system clock (camera pclk is this clock)
//  reset        in   1   synchronous, active-high reset
//  pix_value    in   8   pixel intensity
//  pix_x        in   10  pixel column
//  pix_y        in   10  pixel row
//  pix_val      in   1   pixel strobe; other pix_* are sampled only when high
//  buf_release  in   1   consumer done with bank ready_bank; one-cycle pulse
//  wr_en        out  1   frame-buffer write strobe
//  wr_bank      out  1   bank being written
//  wr_addr      out  AW  linear address y*ROW_SZ+x within bank
//  wr_data      out  8   pixel to write
//  frame_ready  out  1   level: at least one full bank awaits the consumer
//  ready_bank   out  1   oldest full bank (valid while frame_ready)
//  frame_done   out  1   one-cycle pulse when a bank becomes full
//  seq_err      out  1   one-cycle pulse on out-of-sequence pixel
//  drop_cnt     out  8   dropped-frame count, saturates at 255
// BEHAVIOUR
//  - Reset: all outputs 0, both banks empty, cap_bank=0, FSM=SYNC, expected x/y=0.
//  - FSM SYNC: on pix_val with x==0,y==0: if cap_bank empty -> CAPTURE, write pixel;
//    else drop_cnt++ (saturating), remain SYNC (frame ignored until next 0,0).
//  - FSM CAPTURE: each pix_val compared with expected (ex,ey), tracked by counters, no
//    multiply. Match -> write, advance ex (wrap to 0, ey++ at ROW_SZ-1). Mismatch ->
//    seq_err pulse, no write, drop_cnt++, ->SYNC; bank stays empty.
//  - Mismatched pixel is itself (0,0) -> treated as new SYNC start in the same cycle.
//  - Last pixel (ROW_SZ-1,COL_SZ-1) written -> cap_bank marked full, frame_done pulse,
//    cap_bank toggles, ->SYNC.
//  - Write port registered: wr_en/addr/data/bank valid the cycle after sampled pix_val.
//  - wr_addr is a counter incremented per write, reset to 0 at frame start; never y*ROW_SZ
//    by multiplier. wr_data/addr hold last value when wr_en=0.
//  - Bank flags full[1:0]; ready_bank = oldest full (FIFO order, 1-bit pointer).
//    buf_release with frame_ready=0 is ignored. Release and frame completion in the same
//    cycle both take effect; a bank released this cycle is usable by a SYNC start next cycle.
//  - frame_done, ready_bank, frame_ready update the cycle after the last pixel is sampled,
//    aligned with the final wr_en.
//  - pix_val gaps of any length permitted; no timeout.
//  - Reset mid-frame: partial frame discarded, banks emptied, drop_cnt cleared.
// STRUCTURE
//  - cam_pkg: ROW_SZ/COL_SZ defaults, addr-width constant, FSM state encodings (SYNC, CAPTURE).
//  - Sub-module cam_bank_ctrl: full[1:0], cap/read pointers, frame_ready/ready_bank,
//    release handling. Remainder (FSM, counters, write register) inline.
// TESTING (ROW_SZ=4, COL_SZ=3 unless noted)
//  1 Stream one frame, pix_val every other cycle -> 12 writes, addr 0..11, bank 0, frame_done
//    once, frame_ready=1, ready_bank=0.
//  2 Three frames, no buf_release -> frames 1,2 in banks 0,1; frame 3 dropped, drop_cnt=1,
//    no writes.
//  3 Release + frame-2 end same cycle -> frame_ready stays 1, ready_bank=1; next frame writes
//    bank 0.
//  4 Inject (2,1) instead of (1,1) -> seq_err pulse, drop_cnt=1, bank 0 empty, next clean
//    frame lands in bank 0.
//  5 Assert reset after pixel 5 -> all outputs 0; following frame writes addr 0..11 in bank 0.
//  6 Defaults 320x240, back-to-back pix_val -> last write addr 76799, frame_done once.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared constants and FSM encoding for the camera capture path.
package cam_pkg;

    localparam int ROW_SZ_DEF = 320;
    localparam int COL_SZ_DEF = 240;
    localparam int AW_DEF     = 17;

    typedef enum logic {
        SYNC    = 1'b0,
        CAPTURE = 1'b1
    } cap_state_e;

endpackage

// File: rtl/cam_bank_ctrl.sv
// Double-bank ownership: fill pointer, FIFO read pointer and full flags.
module cam_bank_ctrl
    import cam_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic complete,
    input  logic buf_release,
    output logic cap_bank,
    output logic cap_full,
    output logic frame_ready,
    output logic ready_bank
);

    logic [1:0] full;
    logic       cap_ptr;
    logic       rd_ptr;

    // Release targets the oldest bank; completion targets the bank being filled.
    // These are always different banks, so both updates can land together.
    always_ff @(posedge clk) begin
        if (reset) begin
            full    <= 2'b00;
            cap_ptr <= 1'b0;
            rd_ptr  <= 1'b0;
        end else begin
            if (buf_release && (|full)) begin
                full[rd_ptr] <= 1'b0;
                rd_ptr       <= ~rd_ptr;
            end
            if (complete) begin
                full[cap_ptr] <= 1'b1;
                cap_ptr       <= ~cap_ptr;
            end
        end
    end

    assign cap_bank    = cap_ptr;
    assign cap_full    = full[cap_ptr];
    assign frame_ready = |full;
    assign ready_bank  = rd_ptr;

endmodule

// File: rtl/cam_capture.sv
// Camera stream sink: raster-order checker, registered frame-buffer
// write port and double-bank hand-off to the consumer.
module cam_capture
    import cam_pkg::*;
#(
    parameter int ROW_SZ = ROW_SZ_DEF,
    parameter int COL_SZ = COL_SZ_DEF,
    parameter int AW     = AW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    pix_value,
    input  logic [9:0]    pix_x,
    input  logic [9:0]    pix_y,
    input  logic          pix_val,
    input  logic          buf_release,
    output logic          wr_en,
    output logic          wr_bank,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic          frame_ready,
    output logic          ready_bank,
    output logic          frame_done,
    output logic          seq_err,
    output logic [7:0]    drop_cnt
);

    localparam logic [9:0] X_LAST = 10'(ROW_SZ - 1);
    localparam logic [9:0] Y_LAST = 10'(COL_SZ - 1);

    cap_state_e    state, state_n;
    logic [9:0]    ex, ex_n;
    logic [9:0]    ey, ey_n;
    logic [AW-1:0] addr_cnt, addr_n;
    logic [AW-1:0] wa;
    logic          wr_go;
    logic          start;
    logic          advance;
    logic          complete;
    logic          seq_n;
    logic          drop_inc;
    logic          cap_bank;
    logic          cap_full;
    logic          origin;
    logic          match;
    logic          last;

    assign origin = (pix_x == 10'd0) && (pix_y == 10'd0);
    assign match  = (pix_x == ex) && (pix_y == ey);
    assign last   = (ex == X_LAST) && (ey == Y_LAST);

    cam_bank_ctrl u_bank (
        .clk         (clk),
        .reset       (reset),
        .complete    (complete),
        .buf_release (buf_release),
        .cap_bank    (cap_bank),
        .cap_full    (cap_full),
        .frame_ready (frame_ready),
        .ready_bank  (ready_bank)
    );

    always_comb begin
        state_n  = state;
        ex_n     = ex;
        ey_n     = ey;
        addr_n   = addr_cnt;
        wa       = addr_cnt;
        wr_go    = 1'b0;
        start    = 1'b0;
        advance  = 1'b0;
        complete = 1'b0;
        seq_n    = 1'b0;
        drop_inc = 1'b0;

        if (pix_val) begin
            unique case (state)
                SYNC: begin
                    if (origin) begin
                        if (!cap_full) start    = 1'b1;
                        else           drop_inc = 1'b1;
                    end
                end
                CAPTURE: begin
                    if (match) begin
                        advance = 1'b1;
                    end else begin
                        seq_n    = 1'b1;
                        drop_inc = 1'b1;
                        state_n  = SYNC;
                        // A stray (0,0) restarts capture immediately.
                        if (origin && !cap_full) start = 1'b1;
                    end
                end
                default: state_n = SYNC;
            endcase
        end

        if (start) begin
            wr_go   = 1'b1;
            wa      = '0;
            addr_n  = AW'(1);
            ex_n    = 10'd1;
            ey_n    = 10'd0;
            state_n = CAPTURE;
        end

        if (advance) begin
            wr_go  = 1'b1;
            addr_n = addr_cnt + AW'(1);
            if (ex == X_LAST) begin
                ex_n = 10'd0;
                ey_n = ey + 10'd1;
            end else begin
                ex_n = ex + 10'd1;
            end
            if (last) begin
                complete = 1'b1;
                state_n  = SYNC;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= SYNC;
            ex         <= 10'd0;
            ey         <= 10'd0;
            addr_cnt   <= '0;
            wr_en      <= 1'b0;
            wr_bank    <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= 8'd0;
            frame_done <= 1'b0;
            seq_err    <= 1'b0;
            drop_cnt   <= 8'd0;
        end else begin
            state      <= state_n;
            ex         <= ex_n;
            ey         <= ey_n;
            addr_cnt   <= addr_n;
            wr_en      <= wr_go;
            frame_done <= complete;
            seq_err    <= seq_n;
            if (wr_go) begin
                wr_bank <= cap_bank;
                wr_addr <= wa;
                wr_data <= pix_value;
            end
            if (drop_inc && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
        end
    end

endmodule
